// File: rtl/hralm_mult_pipe_pkg.sv
// Shared types and helpers for the hybrid Booth/Mitchell pipelined multiplier.
// Booth digit encoding and leading-one-detector width sizing.
package hralm_mult_pipe_pkg;

   localparam logic MODE_APPROX = 1'b0;
   localparam logic MODE_EXACT  = 1'b1;

   typedef struct packed {
      logic neg;
      logic two;
      logic one;
   } booth_dig_t;

   function automatic int lod_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Triplet 111 encodes zero with neg cleared, so a zero digit never needs a +1.
   function automatic booth_dig_t booth_enc(input logic [2:0] t);
      booth_dig_t d;
      d.one = t[1] ^ t[0];
      d.two = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
      d.neg = t[2] & ~(t[1] & t[0]);
      return d;
   endfunction

endpackage

// File: rtl/hralm_mult_pipe_log_path.sv
// Combinational Mitchell log path: leading-one detect and mantissa extract
// on the S1 side, log add, antilog and one's-complement sign on the S2 side.
module hralm_mult_pipe_log_path #(
   parameter int W    = 16,
   parameter int K    = 14,
   parameter int FRAC = 4,
   parameter int LK   = 5
) (
   input  logic [K-1:0]    s1_a,
   input  logic [W-1:0]    s1_b,
   output logic [LK-1:0]   s1_ka,
   output logic [LK-1:0]   s1_kb,
   output logic [FRAC-1:0] s1_fa,
   output logic [FRAC-1:0] s1_fb,
   output logic            s1_zero,
   input  logic [LK-1:0]   s2_ka,
   input  logic [LK-1:0]   s2_kb,
   input  logic [FRAC-1:0] s2_fa,
   input  logic [FRAC-1:0] s2_fb,
   input  logic            s2_sgn,
   input  logic            s2_zero,
   output logic [K+W-1:0]  s2_low
);

   localparam int LW = K + W;

   // FRAC-1 bits just below the leading one (zero padded), LSB forced to 1.
   function automatic logic [FRAC-1:0] mant(input logic [W-1:0] v, input logic [LK-1:0] k);
      logic [W+FRAC-2:0] t;
      t = {v, {(FRAC-1){1'b0}}} >> k;
      return {t[FRAC-2:0], 1'b1};
   endfunction

   always_comb begin
      s1_ka = '0;
      for (int i = 0; i < K; i++)
         if (s1_a[i]) s1_ka = LK'(i);
      s1_kb = '0;
      for (int i = 0; i < W; i++)
         if (s1_b[i]) s1_kb = LK'(i);
   end

   assign s1_zero = (s1_a == '0) | (s1_b == '0);
   assign s1_fa   = mant({{(W-K){1'b0}}, s1_a}, s1_ka);
   assign s1_fb   = mant(s1_b, s1_kb);

   logic [LK+FRAC-1:0] l_sum;
   logic [LK-1:0]      kint;
   logic [FRAC-1:0]    m;
   logic [LW-1:0]      mag;

   assign l_sum = {s2_ka, s2_fa} + {s2_kb, s2_fb};
   assign kint  = l_sum[LK+FRAC-1:FRAC];
   assign m     = l_sum[FRAC-1:0];
   assign mag   = LW'(({{(LW-1){1'b0}}, 1'b1, m} << kint) >> FRAC);
   assign s2_low = s2_zero ? '0 : (mag ^ {LW{s2_sgn}});

endmodule

// File: rtl/hralm_mult_pipe.sv
// Three-stage hybrid signed multiplier: Booth-recoded high part of x, Mitchell
// log (or exact) low part, valid/ready streaming with full bubble collapse.
module hralm_mult_pipe
   import hralm_mult_pipe_pkg::*;
#(
   parameter int W     = 16,
   parameter int K     = 14,
   parameter int FRAC  = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_x,
   input  logic [W-1:0]     in_y,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NDIG = (W - K) / 2;
   localparam int LK   = lod_w(W) + 1;
   localparam int LW   = K + W;
   localparam int PW   = W + 1;
   localparam int P2   = 2 * W;

   typedef struct packed {
      booth_dig_t [NDIG-1:0] dig;
      logic [LK-1:0]         ka;
      logic [LK-1:0]         kb;
      logic [FRAC-1:0]       fa;
      logic [FRAC-1:0]       fb;
      logic                  zero;
      logic                  sgn;
      logic                  mode;
      logic [K-1:0]          x_lo;
      logic [W-1:0]          y;
      logic [TAG_W-1:0]      tag;
   } s1_t;

   typedef struct packed {
      logic [LW-1:0]            low;
      logic [NDIG-1:0][PW-1:0]  pp;
      logic [NDIG-1:0]          sf;
      logic [TAG_W-1:0]         tag;
   } s2_t;

   logic v1, v2, v3;
   logic adv2, adv3;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;

   assign out_valid = v3;
   assign adv3      = ~v3 | out_ready;
   assign adv2      = ~v2 | adv3;
   assign in_ready  = ~v1 | adv2;

   // S1: one's-complement magnitudes feed the log path; no +1 by design.
   logic [K-1:0]    a_abs;
   logic [W-1:0]    b_abs;
   logic [LK-1:0]   ka_w, kb_w;
   logic [FRAC-1:0] fa_w, fb_w;
   logic            zero_w;
   logic [LW-1:0]   lo_approx;

   assign a_abs = in_x[K-1:0] ^ {K{in_x[K-1]}};
   assign b_abs = in_y ^ {W{in_y[W-1]}};

   hralm_mult_pipe_log_path #(
      .W    (W),
      .K    (K),
      .FRAC (FRAC),
      .LK   (LK)
   ) u_log_path (
      .s1_a    (a_abs),
      .s1_b    (b_abs),
      .s1_ka   (ka_w),
      .s1_kb   (kb_w),
      .s1_fa   (fa_w),
      .s1_fb   (fb_w),
      .s1_zero (zero_w),
      .s2_ka   (s1_q.ka),
      .s2_kb   (s1_q.kb),
      .s2_fa   (s1_q.fa),
      .s2_fb   (s1_q.fb),
      .s2_sgn  (s1_q.sgn),
      .s2_zero (s1_q.zero),
      .s2_low  (lo_approx)
   );

   always_comb begin
      s1_d = '0;
      for (int j = 0; j < NDIG; j++)
         s1_d.dig[j] = booth_enc(in_x[K+2*j+1 -: 3]);
      s1_d.ka   = ka_w;
      s1_d.kb   = kb_w;
      s1_d.fa   = fa_w;
      s1_d.fb   = fb_w;
      s1_d.zero = zero_w;
      s1_d.sgn  = in_x[K-1] ^ in_y[W-1];
      s1_d.mode = (in_mode == MODE_EXACT) ? MODE_EXACT : MODE_APPROX;
      s1_d.x_lo = in_x[K-1:0];
      s1_d.y    = in_y;
      s1_d.tag  = in_tag;
   end

   // S2: Booth rows; neg only ever set together with one|two.
   logic [NDIG-1:0][PW-1:0] pp_w;
   logic [NDIG-1:0]         sf_w;
   logic signed [LW-1:0]    lo_exact;

   for (genvar j = 0; j < NDIG; j++) begin : g_booth
      logic [PW-1:0] row;
      assign row = s1_q.dig[j].one ? {s1_q.y[W-1], s1_q.y} :
                   (s1_q.dig[j].two ? {s1_q.y, 1'b0} : '0);
      assign pp_w[j] = row ^ {PW{s1_q.dig[j].neg}};
      assign sf_w[j] = s1_q.dig[j].neg & (s1_q.dig[j].one | s1_q.dig[j].two);
   end

   assign lo_exact = $signed(s1_q.x_lo) * $signed(s1_q.y);

   always_comb begin
      s2_d     = '0;
      s2_d.low = (s1_q.mode == MODE_APPROX) ? lo_approx : lo_exact;
      s2_d.pp  = pp_w;
      s2_d.sf  = sf_w;
      s2_d.tag = s1_q.tag;
   end

   // S3: final accumulation, everything mod 2^(2W).
   logic [P2-1:0] p_sum;

   always_comb begin
      p_sum = {{(P2-LW){s2_q.low[LW-1]}}, s2_q.low};
      for (int j = 0; j < NDIG; j++)
         p_sum = p_sum + (({{(P2-PW){s2_q.pp[j][PW-1]}}, s2_q.pp[j]} +
                           {{(P2-1){1'b0}}, s2_q.sf[j]}) << (K + 2*j));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (in_ready) v1 <= in_valid;
         if (adv2)     v2 <= v1;
         if (adv3)     v3 <= v2;
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) s1_q <= s1_d;
      if (v1 && adv2)           s2_q <= s2_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_p   <= '0;
         out_tag <= '0;
      end else if (v2 && adv3) begin
         out_p   <= p_sum;
         out_tag <= s2_q.tag;
      end
   end

endmodule
